// File: rtl/branch_predictor.sv
// branch_predictor
//   Fetch-stage branch direction predictor built on a table of 2-bit
//   saturating counters (BHT) indexed by pc[INDEX_BITS+1:2].
//   After reset the table is walked once, one entry per cycle, and every
//   entry is loaded with weakly-not-taken. Requests and updates are ignored
//   until that walk completes.
//
//   Optional feature: define BP_STATS_EN to add branch / mispredict counters.
//
// Ports
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   o_ready             table initialised, requests accepted
//   i_pred_req/pc       prediction request from fetch
//   o_pred_valid/taken  prediction result, one cycle after the request
//   i_upd_valid/pc      resolved conditional branch from execute
//   i_upd_taken         actual outcome
//   i_upd_pred          prediction that travelled with the branch
//   o_mispredict        one-cycle pulse when outcome differed from prediction
//   o_branch_count      (BP_STATS_EN) accepted updates
//   o_mispredict_count  (BP_STATS_EN) mispredict pulses
module branch_predictor #(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic                  o_ready,
    input  logic                  i_pred_req,
    input  logic [ADDR_WIDTH-1:0] i_pred_pc,
    output logic                  o_pred_valid,
    output logic                  o_pred_taken,
    input  logic                  i_upd_valid,
    input  logic [ADDR_WIDTH-1:0] i_upd_pc,
    input  logic                  i_upd_taken,
    input  logic                  i_upd_pred,
    output logic                  o_mispredict
`ifdef BP_STATS_EN
    ,
    output logic [31:0]           o_branch_count,
    output logic [31:0]           o_mispredict_count
`endif
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state;
    logic [INDEX_BITS-1:0] init_idx;
    logic [1:0]            bht [ENTRIES];

    logic [INDEX_BITS-1:0] pred_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [1:0]            upd_cnt;
    logic [1:0]            upd_next;
    logic                  run;
    logic                  upd_fire;
    logic                  pred_fire;
    logic                  pred_bit;
    logic                  unused_pc_bits;

    always_comb begin
        run       = (state == ST_RUN);
        pred_idx  = i_pred_pc[INDEX_BITS+1:2];
        upd_idx   = i_upd_pc[INDEX_BITS+1:2];
        upd_fire  = run && i_upd_valid;
        pred_fire = run && i_pred_req;
        upd_cnt   = bht[upd_idx];
        upd_next  = upd_cnt;
        if (i_upd_taken) begin
            if (upd_cnt != 2'b11) upd_next = upd_cnt + 2'd1;
        end else begin
            if (upd_cnt != 2'b00) upd_next = upd_cnt - 2'd1;
        end
        // Write-first: a same-cycle update to the predicted entry is visible
        // to the prediction.
        if (upd_fire && (upd_idx == pred_idx))
            pred_bit = upd_next[1];
        else
            pred_bit = bht[pred_idx][1];
        o_ready = run;
    end

    // Only the index bits of the PCs select an entry; there is no tag.
    assign unused_pc_bits = ^{i_pred_pc[ADDR_WIDTH-1:INDEX_BITS+2], i_pred_pc[1:0],
                              i_upd_pc[ADDR_WIDTH-1:INDEX_BITS+2], i_upd_pc[1:0]};

    // Table has no reset of its own: the INIT walk reloads every entry.
    always_ff @(posedge i_clk) begin
        if (!run)
            bht[init_idx] <= 2'b01;
        else if (upd_fire)
            bht[upd_idx] <= upd_next;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= ST_INIT;
            init_idx     <= '0;
            o_pred_valid <= 1'b0;
            o_pred_taken <= 1'b0;
            o_mispredict <= 1'b0;
        end else begin
            if (state == ST_INIT) begin
                init_idx <= init_idx + INDEX_BITS'(1);
                if (init_idx == '1)
                    state <= ST_RUN;
            end
            o_pred_valid <= pred_fire;
            if (pred_fire)
                o_pred_taken <= pred_bit;
            o_mispredict <= upd_fire && (i_upd_taken != i_upd_pred);
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_branch_count     <= '0;
            o_mispredict_count <= '0;
        end else begin
            if (upd_fire)
                o_branch_count <= o_branch_count + 32'd1;
            if (upd_fire && (i_upd_taken != i_upd_pred))
                o_mispredict_count <= o_mispredict_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor
//   Randomised and directed stimulus for branch_predictor. The driver keeps a
//   reference model (array of integer counters, init countdown) and queues the
//   expected outputs for every clock edge it drives; a monitor pops and checks.
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic        ready;
    logic        pred_req;
    logic [31:0] pred_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_pred;
    logic        mispredict;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    branch_predictor #(.INDEX_BITS(6), .ADDR_WIDTH(32)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .o_ready      (ready),
        .i_pred_req   (pred_req),
        .i_pred_pc    (pred_pc),
        .o_pred_valid (pred_valid),
        .o_pred_taken (pred_taken),
        .i_upd_valid  (upd_valid),
        .i_upd_pc     (upd_pc),
        .i_upd_taken  (upd_taken),
        .i_upd_pred   (upd_pred),
        .o_mispredict (mispredict)
`ifdef BP_STATS_EN
        ,
        .o_branch_count     (branch_count),
        .o_mispredict_count (mispredict_count)
`endif
    );

`ifndef BP_STATS_EN
    assign branch_count     = '0;
    assign mispredict_count = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rdy;
        bit          pv;
        bit          pt;
        bit          mis;
        int unsigned bc;
        int unsigned mc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model state
    int          cnt[64];
    int          init_left = 64;
    bit          last_pt = 1'b0;
    int unsigned bc = 0;
    int unsigned mc = 0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step(input bit rst, input bit req, input logic [31:0] ppc,
                        input bit uv, input logic [31:0] upc, input bit ut, input bit up);
        exp_t e;
        @(negedge clk);
        rst_n     = rst;
        pred_req  = req;
        pred_pc   = ppc;
        upd_valid = uv;
        upd_pc    = upc;
        upd_taken = ut;
        upd_pred  = up;
        e = '{rdy: 1'b0, pv: 1'b0, pt: 1'b0, mis: 1'b0, bc: 0, mc: 0};
        if (!rst) begin
            for (int i = 0; i < 64; i++) cnt[i] = 1;
            init_left = 64;
            last_pt   = 1'b0;
            bc        = 0;
            mc        = 0;
        end else if (init_left > 0) begin
            init_left--;
            e.rdy = (init_left == 0);
        end else begin
            e.rdy = 1'b1;
            if (uv) begin
                int k = idx_of(upc);
                if (ut) cnt[k] = (cnt[k] == 3) ? 3 : cnt[k] + 1;
                else    cnt[k] = (cnt[k] == 0) ? 0 : cnt[k] - 1;
                bc++;
                if (ut != up) begin
                    e.mis = 1'b1;
                    mc++;
                end
            end
            e.pv = req;
            if (req) last_pt = (cnt[idx_of(ppc)] >= 2);
        end
        e.pt = last_pt;
        e.bc = bc;
        e.mc = mc;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] pc, input bit t, input bit p);
        step(1'b1, 1'b0, 32'h0, 1'b1, pc, t, p);
    endtask

    task automatic pred(input logic [31:0] pc);
        step(1'b1, 1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // Releases reset and measures cycles until o_ready; init-time updates
    // are issued to show that they are ignored.
    task automatic wait_ready(input string name);
        int n = 0;
        while (n < 200) begin
            step(1'b1, 1'($urandom_range(1)), $urandom, 1'b1, $urandom, 1'($urandom_range(1)), 1'b0);
            @(posedge clk);
            #1;
            n++;
            if (ready === 1'b1) break;
        end
        chk(name, 32'(n), 32'd64);
    endtask

    // Monitor: one expectation per driven edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("o_ready", 32'(ready), 32'(e.rdy));
                chk("o_pred_valid", 32'(pred_valid), 32'(e.pv));
                chk("o_pred_taken", 32'(pred_taken), 32'(e.pt));
                chk("o_mispredict", 32'(mispredict), 32'(e.mis));
`ifdef BP_STATS_EN
                chk("o_branch_count", branch_count, e.bc);
                chk("o_mispredict_count", mispredict_count, e.mc);
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; pred_req = 1'b0; pred_pc = '0; upd_valid = 1'b0;
        upd_pc = '0; upd_taken = 1'b0; upd_pred = 1'b0;

        // 1. reset, init latency, first predictions read WNT
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        wait_ready("ready_latency");
        pred(32'h100);
        pred(32'h2fc);
        idle();

        // 2. saturation up and down at pc 0x100
        upd(32'h100, 1'b1, 1'b0);
        pred(32'h100);
        upd(32'h100, 1'b1, 1'b1);
        upd(32'h100, 1'b1, 1'b1);
        pred(32'h100);
        for (int i = 0; i < 3; i++) upd(32'h100, 1'b0, 1'b1);
        pred(32'h100);
        upd(32'h100, 1'b0, 1'b0);
        pred(32'h101);

        // 3. mispredict pulse
        upd(32'h40, 1'b1, 1'b0);
        idle();
        upd(32'h40, 1'b1, 1'b1);
        idle();

        // 4. same-cycle bypass at WNT, then aliasing 0x80 / 0x180
        step(1'b1, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 1'b0);
        pred(32'h180);
        upd(32'h180, 1'b0, 1'b1);
        upd(32'h180, 1'b0, 1'b1);
        pred(32'h80);

        // random traffic with a narrow index range to force collisions
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a, b;
            a = {$urandom_range(255), 2'($urandom_range(3))} & 32'h3ff;
            a = a | ($urandom_range(3) << 12);
            b = ($urandom_range(3) == 0) ? a : (32'($urandom_range(15)) << 2);
            a = ($urandom_range(1) == 1) ? (32'($urandom_range(15)) << 2) : a;
            if ($urandom_range(499) == 0) begin
                step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
                wait_ready("ready_latency_rand");
            end else begin
                step(1'b1, 1'($urandom_range(1)), a, 1'($urandom_range(1)), b,
                     1'($urandom_range(1)), 1'($urandom_range(1)));
            end
        end

        // 5. reset in the middle of INIT, then every entry must read WNT
        for (int i = 0; i < 64; i++) upd(32'(i * 4), 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++)
            step(1'b1, 1'b0, 32'h0, 1'b1, 32'(i * 4), 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        wait_ready("ready_latency_midinit");
        for (int i = 0; i < 64; i++) pred(32'(i * 4 + 32'h1000));

        // 6. ten updates, three mispredicted
        for (int i = 0; i < 10; i++)
            upd(32'(i * 8), 1'($urandom_range(1)) | 1'b1, (i % 3 == 0 && i > 0) ? 1'b0 : 1'b1);
        idle();
        repeat (3) @(posedge clk);
        #3;
`ifdef BP_STATS_EN
        chk("branch_count_10", branch_count, 32'd10);
        chk("mispredict_count_3", mispredict_count, 32'd3);
`endif
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
